// File: rtl/instruction_fetch_unit.sv
// ============================================================================
// Module   : instruction_fetch_unit
// Brief    : Reads two bytes at PC (little-endian) into a 16-bit IR and
//            post-increments PC through the address register file.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module instruction_fetch_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int WAIT_LIMIT = 15
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic                  i_flush,
  input  logic [ADDR_WIDTH-1:0] i_pc_in,
  input  logic                  i_mem_ready,
  input  logic [7:0]            i_mem_data,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_read,
  output logic [1:0]            o_arf_outd_sel,
  output logic [2:0]            o_arf_reg_sel,
  output logic [1:0]            o_arf_fun_sel,
  output logic [15:0]           o_ir,
  output logic                  o_instr_valid,
  output logic                  o_busy,
  output logic                  o_fault
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH_LO = 2'd1,
    FETCH_HI = 2'd2,
    DONE     = 2'd3
  } state_t;

  // Counter value on the last permitted waiting cycle; one more miss times out.
  localparam logic [7:0] c_wait_last = 8'(WAIT_LIMIT - 1);

  state_t      r_state;
  state_t      w_next_state;
  logic [15:0] r_ir;
  logic [7:0]  r_wait_cnt;
  logic        r_fault;

  logic        w_inc;
  logic        w_lo_en;
  logic        w_hi_en;
  logic        w_wait_clr;
  logic        w_wait_inc;
  logic        w_fault_set;
  logic        w_fault_clr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= IDLE;
      r_ir       <= 16'h0000;
      r_wait_cnt <= 8'd0;
      r_fault    <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_lo_en) r_ir[7:0]  <= i_mem_data;
      if (w_hi_en) r_ir[15:8] <= i_mem_data;
      if (w_wait_clr)      r_wait_cnt <= 8'd0;
      else if (w_wait_inc) r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_fault_clr)      r_fault <= 1'b0;
      else if (w_fault_set) r_fault <= 1'b1;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_inc        = 1'b0;
    w_lo_en      = 1'b0;
    w_hi_en      = 1'b0;
    w_wait_clr   = 1'b0;
    w_wait_inc   = 1'b0;
    w_fault_set  = 1'b0;
    w_fault_clr  = 1'b0;

    // Flush overrides every state and suppresses byte capture and increment.
    if (i_flush) begin
      w_next_state = IDLE;
    end else begin
      case (r_state)
        IDLE: begin
          if (i_start) begin
            w_next_state = FETCH_LO;
            w_wait_clr   = 1'b1;
            w_fault_clr  = 1'b1;
          end
        end
        FETCH_LO, FETCH_HI: begin
          if (i_mem_ready) begin
            w_inc        = 1'b1;
            w_lo_en      = (r_state == FETCH_LO);
            w_hi_en      = (r_state == FETCH_HI);
            w_wait_clr   = 1'b1;
            w_next_state = (r_state == FETCH_LO) ? FETCH_HI : DONE;
          end else begin
            w_wait_inc = 1'b1;
            if (r_wait_cnt == c_wait_last) begin
              w_fault_set  = 1'b1;
              w_next_state = IDLE;
            end
          end
        end
        DONE: begin
          if (i_start) begin
            w_next_state = FETCH_LO;
            w_wait_clr   = 1'b1;
            w_fault_clr  = 1'b1;
          end else begin
            w_next_state = IDLE;
          end
        end
        default: w_next_state = IDLE;
      endcase
    end
  end

  assign o_busy         = (r_state == FETCH_LO) || (r_state == FETCH_HI);
  assign o_mem_read     = o_busy;
  assign o_mem_addr     = i_pc_in;
  assign o_arf_outd_sel = 2'b00;
  assign o_arf_reg_sel  = w_inc ? 3'b100 : 3'b000;
  assign o_arf_fun_sel  = w_inc ? 2'b01 : 2'b00;
  assign o_ir           = r_ir;
  assign o_instr_valid  = (r_state == DONE);
  assign o_fault        = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_unit.sv
// ============================================================================
// Module   : tb_instruction_fetch_unit
// Brief    : Scoreboard bench; two instances (WAIT_LIMIT 15 and 4) share
//            stimulus, each with its own PC model and byte memory port.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        flush;
  logic        ready;

  logic [15:0] pc15, pc4;
  logic        pc_load = 1'b0;
  logic [15:0] pc_val  = 16'h0000;
  int          sc15 = 0;
  int          sc4  = 0;

  logic [7:0]  mem [0:65535];
  logic [7:0]  data15, data4;

  logic [15:0] addr15, addr4;
  logic        read15, read4;
  logic [1:0]  outd15, outd4;
  logic [2:0]  rsel15, rsel4;
  logic [1:0]  fsel15, fsel4;
  logic [15:0] ir15, ir4;
  logic        valid15, valid4;
  logic        busy15, busy4;
  logic        fault15, fault4;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q [$];

  always #5 clk = ~clk;

  assign data15 = mem[pc15];
  assign data4  = mem[pc4];

  instruction_fetch_unit #(.ADDR_WIDTH(16), .WAIT_LIMIT(15)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_flush(flush),
    .i_pc_in(pc15), .i_mem_ready(ready), .i_mem_data(data15),
    .o_mem_addr(addr15), .o_mem_read(read15), .o_arf_outd_sel(outd15),
    .o_arf_reg_sel(rsel15), .o_arf_fun_sel(fsel15), .o_ir(ir15),
    .o_instr_valid(valid15), .o_busy(busy15), .o_fault(fault15)
  );

  instruction_fetch_unit #(.ADDR_WIDTH(16), .WAIT_LIMIT(4)) u_dut4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_flush(flush),
    .i_pc_in(pc4), .i_mem_ready(ready), .i_mem_data(data4),
    .o_mem_addr(addr4), .o_mem_read(read4), .o_arf_outd_sel(outd4),
    .o_arf_reg_sel(rsel4), .o_arf_fun_sel(fsel4), .o_ir(ir4),
    .o_instr_valid(valid4), .o_busy(busy4), .o_fault(fault4)
  );

  // Address register file model: PC load from the bench or increment strobe.
  always @(posedge clk) begin
    if (pc_load) begin
      pc15 <= pc_val;
      pc4  <= pc_val;
    end else begin
      if (rsel15 == 3'b100 && fsel15 == 2'b01) begin
        pc15 <= pc15 + 16'd1;
        sc15 <= sc15 + 1;
      end
      if (rsel4 == 3'b100 && fsel4 == 2'b01) begin
        pc4 <= pc4 + 16'd1;
        sc4 <= sc4 + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pc_set(input logic [15:0] v);
    pc_val  = v;
    pc_load = 1'b1;
    tick();
    pc_load = 1'b0;
  endtask

  // Monitor: every InstrValid pulse must match the oldest expected IR.
  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && valid15 === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL ir_unexpected: got valid with ir=%h expected no valid", ir15);
        end else begin
          e = exp_q.pop_front();
          chk("ir_scoreboard", ir15, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sc_before;
    rst_n = 1'b0;
    start = 1'b0;
    flush = 1'b0;
    ready = 1'b0;
    mem[16'h0010] = 8'h34; mem[16'h0011] = 8'h12;
    mem[16'h0020] = 8'h78; mem[16'h0021] = 8'h56;
    mem[16'h0022] = 8'h9A; mem[16'h0023] = 8'hBC;
    mem[16'h0030] = 8'h11; mem[16'h0031] = 8'h22;
    mem[16'hFFFF] = 8'hCD; mem[16'h0000] = 8'hAB;
    mem[16'h0001] = 8'hEF; mem[16'h0002] = 8'h01;
    mem[16'h0040] = 8'h55; mem[16'h0041] = 8'h66;
    pc_set(16'h0000);
    tick();
    chk("rst_ir", ir15, 16'h0000);
    chk("rst_valid", valid15, 1'b0);
    chk("rst_fault", fault15, 1'b0);
    chk("rst_busy", busy15, 1'b0);
    chk("rst_read", read15, 1'b0);
    chk("rst_regsel", rsel15, 3'b000);
    chk("rst_outdsel", outd15, 2'b00);
    rst_n = 1'b1;
    tick();

    // Basic fetch at 0x0010
    pc_set(16'h0010);
    sc_before = sc15;
    ready = 1'b1;
    exp_q.push_back(16'h1234);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("basic_busy_lo", busy15, 1'b1);
    chk("basic_addr_lo", addr15, 16'h0010);
    chk("basic_regsel_lo", rsel15, 3'b100);
    chk("basic_funsel_lo", fsel15, 2'b01);
    tick();
    chk("basic_addr_hi", addr15, 16'h0011);
    chk("basic_regsel_hi", rsel15, 3'b100);
    tick();
    chk("basic_valid_c3", valid15, 1'b1);
    chk("basic_ir", ir15, 16'h1234);
    tick();
    chk("basic_valid_c4", valid15, 1'b0);
    chk("basic_busy_idle", busy15, 1'b0);
    chk("basic_strobes", sc15 - sc_before, 2);

    // Wait states: three cycles without MemReady in FETCH_LO
    pc_set(16'h0020);
    ready = 1'b0;
    exp_q.push_back(16'h5678);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_no_strobe", rsel15, 3'b000);
      chk("wait_busy", busy15, 1'b1);
      tick();
    end
    ready = 1'b1;
    #1;
    chk("wait_strobe_on_ready", rsel15, 3'b100);
    tick();
    chk("wait_ir_lo", ir15[7:0], 8'h78);
    tick();
    tick();
    chk("wait_fault15", fault15, 1'b0);
    chk("wait_fault4", fault4, 1'b0);

    // Timeout on the WAIT_LIMIT=4 instance
    ready = 1'b0;
    sc_before = sc4;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    chk("to_fault_before", fault4, 1'b0);
    chk("to_busy_before", busy4, 1'b1);
    tick();
    chk("to_fault_set", fault4, 1'b1);
    chk("to_idle", busy4, 1'b0);
    chk("to_no_strobe", sc4 - sc_before, 0);
    chk("to_ir_kept", ir4, 16'h5678);
    chk("to_other_busy", busy15, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("to_flush_idle", busy15, 1'b0);
    chk("to_fault15", fault15, 1'b0);
    chk("to_fault_sticky", fault4, 1'b1);
    ready = 1'b1;
    exp_q.push_back(16'hBC9A);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("to_fault_cleared", fault4, 1'b0);
    tick();
    tick();
    tick();

    // Flush in FETCH_HI with MemReady high
    pc_set(16'h0030);
    sc_before = sc15;
    ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    flush = 1'b1;
    #1;
    chk("flush_no_strobe", rsel15, 3'b000);
    tick();
    flush = 1'b0;
    chk("flush_idle", busy15, 1'b0);
    chk("flush_ir", ir15, 16'hBC11);
    chk("flush_strobes", sc15 - sc_before, 1);
    tick();
    chk("flush_no_valid", valid15, 1'b0);

    // Back-to-back with wrap-around at 0xFFFF
    pc_set(16'hFFFF);
    exp_q.push_back(16'hABCD);
    exp_q.push_back(16'h01EF);
    start = 1'b1;
    tick();
    chk("wrap_addr_lo", addr15, 16'hFFFF);
    tick();
    chk("wrap_addr_hi", addr15, 16'h0000);
    tick();
    chk("wrap_valid", valid15, 1'b1);
    tick();
    chk("b2b_busy", busy15, 1'b1);
    chk("b2b_addr", addr15, 16'h0001);
    start = 1'b0;
    tick();
    chk("b2b_addr_hi", addr15, 16'h0002);
    tick();
    tick();
    chk("b2b_pc", pc15, 16'h0003);

    // Asynchronous reset in the middle of FETCH_HI
    pc_set(16'h0040);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("arst_strobe_before", rsel15, 3'b100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ir", ir15, 16'h0000);
    chk("arst_busy", busy15, 1'b0);
    chk("arst_regsel", rsel15, 3'b000);
    chk("arst_funsel", fsel15, 2'b00);
    chk("arst_read", read15, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    ready = 1'b0;
    tick();
    chk("arst_pc", pc15, 16'h0041);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch sequencer directly downstream of the address register file.
- Takes the PC value presented on the address register file's OutD port (OutDSel forced to PC) and reads two consecutive bytes from byte-wide memory.
- Assembles the two bytes little-endian into a 16-bit instruction register.
- Drives the address register file's RegSel/FunSel to post-increment PC once per byte.

Parameters:
- ADDR_WIDTH, 16, width of the address bus and of PCIn.
- WAIT_LIMIT, 15, maximum number of consecutive cycles a fetch state waits for MemReady before aborting with Fault; legal range 1..255.

Ports:
- Clock  input  1  single system clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  request one instruction fetch; sampled in IDLE and DONE.
- Flush  input  1  synchronous abort; returns the FSM to IDLE.
- PCIn  input  ADDR_WIDTH  PC value from the address register file's OutD.
- MemReady  input  1  memory read data valid this cycle.
- MemData  input  8  memory read data byte.
- MemAddr  output  ADDR_WIDTH  memory address.
- MemRead  output  1  memory read strobe.
- ARF_OutDSel  output  2  constant 2'b00 (selects PC).
- ARF_RegSel  output  3  register enables; bit 2 = PC, bit 1 = SP, bit 0 = AR.
- ARF_FunSel  output  2  register function; 01 = increment.
- IR  output  16  instruction register.
- InstrValid  output  1  one-cycle pulse when IR holds a new instruction.
- Busy  output  1  high in FETCH_LO and FETCH_HI.
- Fault  output  1  sticky memory-timeout flag.

Behaviour:
- Reset is asynchronous, active-low. While Reset = 0: state = IDLE, IR = 16'h0000, InstrValid = 0, Fault = 0, wait counter = 0.
- Outputs are combinational from state:
  - MemAddr = PCIn.
  - MemRead = Busy.
  - ARF_OutDSel = 2'b00 always.
- States: IDLE, FETCH_LO, FETCH_HI, DONE.
- IDLE:
  - Start = 1 and Flush = 0 -> FETCH_LO, and clear the wait counter and Fault.
  - Otherwise remain in IDLE.
- FETCH_LO:
  - If MemReady = 1: IR[7:0] <= MemData; drive ARF_RegSel = 3'b100 and ARF_FunSel = 2'b01 for exactly this cycle (PC+1 at the same edge); clear the wait counter; go to FETCH_HI.
  - If MemReady = 0: wait counter += 1.
- FETCH_HI:
  - Same as FETCH_LO, but the byte goes to IR[15:8] and the next state is DONE.
  - Since PC increments at the FETCH_LO edge, PCIn already equals PC+1 in FETCH_HI.
- DONE:
  - InstrValid = 1 for this single cycle.
  - Start = 1 -> FETCH_LO (back-to-back fetch, no IDLE bubble); else -> IDLE.
- Increment strobe: ARF_RegSel = 3'b000 and ARF_FunSel = 2'b00 in every cycle without an increment. Exactly one PC increment per accepted byte.
- Timeout:
  - If the wait counter reaches WAIT_LIMIT while MemReady = 0 in a fetch state -> Fault <= 1, state <= IDLE.
  - No PC increment on a timeout; IR keeps the bytes already latched.
  - Fault stays set until the next accepted Start.
- Flush:
  - Has priority over everything except Reset. In any state it forces IDLE at the next edge.
  - If MemReady = 1 in the same cycle, the byte is not latched and no increment is issued.
  - IR keeps its value; no InstrValid is produced.
- Wrap-around: PC at 16'hFFFF is fetched normally. The ARF increment wraps it to 16'h0000, so the high byte is read from 16'h0000.
- Reset mid-fetch: immediate return to IDLE with the reset values listed above; no increment strobe while Reset = 0.
- Latency with zero wait states: Start accepted at edge 0, FETCH_LO at cycle 1, FETCH_HI at cycle 2, InstrValid in cycle 3.

Test Plan:
- Basic fetch: Reset low, then high; PC = 16'h0010, mem[0x10] = 8'h34, mem[0x11] = 8'h12, MemReady = 1, one-cycle Start -> MemAddr 0x0010 then 0x0011; two PC-increment strobes (RegSel 100, FunSel 01); IR = 16'h1234; InstrValid high for one cycle in cycle 3.
- Wait states: MemReady held low 3 cycles in FETCH_LO with WAIT_LIMIT = 15 -> no strobe while waiting; IR[7:0] latched in the first cycle with MemReady = 1; Fault stays 0.
- Timeout: MemReady held low with WAIT_LIMIT = 4 -> Fault = 1 after 4 waiting cycles; state returns to IDLE; no PC strobe; next Start clears Fault.
- Flush: Flush asserted in FETCH_HI together with MemReady = 1 -> IDLE next cycle; IR[15:8] unchanged; exactly one increment total; no InstrValid.
- Back-to-back with wrap: Start held high, PC = 16'hFFFF, mem[0xFFFF] = 8'hCD, mem[0x0000] = 8'hAB -> IR = 16'hABCD; DONE goes directly to FETCH_LO; the second instruction fetches from 0x0001.
- Async reset: Reset low mid-FETCH_HI, between clock edges -> IR = 0, Busy = 0, strobe outputs 0 immediately, without waiting for a clock edge.
